// File: rtl/cr_mask_pipe.sv
`default_nettype none
// ============================================================================
// Module   : cr_mask_pipe
// Function : Pixel-rate RGB888 -> Cr conversion with a programmable Cr
//            window. Produces a chroma mask aligned with delayed pixel
//            coordinates, and reports the masked-pixel count per frame.
// Options  : CR_MASK_ERODE_EN adds a 3-tap horizontal erosion stage
//            (latency 5 instead of 4).
// Revision : 1.0 - initial release
// ============================================================================
module cr_mask_pipe #(
  parameter int H_ACTIVE = 1024,
  parameter int V_ACTIVE = 768,
  parameter int CNT_W    = 20
) (
  input  logic             clk_65mhz,
  input  logic             rst_in,
  input  logic [10:0]      hcount_in,
  input  logic [9:0]       vcount_in,
  input  logic [23:0]      pixel_in,
  input  logic [7:0]       cr_lo_in,
  input  logic [7:0]       cr_hi_in,
  output logic [10:0]      hcount_out,
  output logic [9:0]       vcount_out,
  output logic [7:0]       cr_out,
  output logic             mask_out,
  output logic [CNT_W-1:0] count_out,
  output logic             count_valid_out
);

  localparam logic [10:0]      c_h_act   = 11'(H_ACTIVE);
  localparam logic [9:0]       c_v_act   = 10'(V_ACTIVE);
  localparam logic [CNT_W-1:0] c_cnt_max = {CNT_W{1'b1}};

  // Threshold shadow: a new window is captured only at the input-side frame
  // start, and each pixel carries its own window copy down the pipe so that
  // pixels of the previous frame still in flight keep the old window.
  logic       w_fs_in;
  logic [7:0] lo_act_d, hi_act_d;
  logic [7:0] lo_act_q, hi_act_q;

  assign w_fs_in  = (hcount_in == '0) && (vcount_in == '0);
  assign lo_act_d = w_fs_in ? cr_lo_in : lo_act_q;
  assign hi_act_d = w_fs_in ? cr_hi_in : hi_act_q;

  // S1 stage registers
  logic        s1_vld_q;
  logic [23:0] s1_pix_q;
  logic [10:0] s1_h_q;
  logic [9:0]  s1_v_q;
  logic [7:0]  s1_lo_q, s1_hi_q;
  // S2 stage registers
  logic        s2_vld_q;
  logic [14:0] s2_pr_q, s2_pg_q, s2_pb_q;
  logic [10:0] s2_h_q;
  logic [9:0]  s2_v_q;
  logic [7:0]  s2_lo_q, s2_hi_q;
  // S3 stage registers
  logic               s3_vld_q;
  logic signed [16:0] s3_sum_q;
  logic [10:0]        s3_h_q;
  logic [9:0]         s3_v_q;
  logic [7:0]         s3_lo_q, s3_hi_q;

  // Active window shadow and S1 input capture
  always_ff @(posedge clk_65mhz or negedge rst_in) begin
    if (!rst_in) begin
      lo_act_q <= '0;
      hi_act_q <= '0;
      s1_vld_q <= 1'b0;
      s1_pix_q <= '0;
      s1_h_q   <= '0;
      s1_v_q   <= '0;
      s1_lo_q  <= '0;
      s1_hi_q  <= '0;
    end else begin
      lo_act_q <= lo_act_d;
      hi_act_q <= hi_act_d;
      s1_vld_q <= 1'b1;
      s1_pix_q <= pixel_in;
      s1_h_q   <= hcount_in;
      s1_v_q   <= vcount_in;
      s1_lo_q  <= lo_act_d;
      s1_hi_q  <= hi_act_d;
    end
  end

  // S2: the three unsigned weight products
  always_ff @(posedge clk_65mhz or negedge rst_in) begin
    if (!rst_in) begin
      s2_vld_q <= 1'b0;
      s2_pr_q  <= '0;
      s2_pg_q  <= '0;
      s2_pb_q  <= '0;
      s2_h_q   <= '0;
      s2_v_q   <= '0;
      s2_lo_q  <= '0;
      s2_hi_q  <= '0;
    end else begin
      s2_vld_q <= s1_vld_q;
      s2_pr_q  <= 15'(s1_pix_q[23:16]) * 15'd112;
      s2_pg_q  <= 15'(s1_pix_q[15:8])  * 15'd94;
      s2_pb_q  <= 15'(s1_pix_q[7:0])   * 15'd18;
      s2_h_q   <= s1_h_q;
      s2_v_q   <= s1_v_q;
      s2_lo_q  <= s1_lo_q;
      s2_hi_q  <= s1_hi_q;
    end
  end

  // S3: signed sum 112R - 94G - 18B (fits 17 bits: |sum| <= 28560)
  always_ff @(posedge clk_65mhz or negedge rst_in) begin
    if (!rst_in) begin
      s3_vld_q <= 1'b0;
      s3_sum_q <= '0;
      s3_h_q   <= '0;
      s3_v_q   <= '0;
      s3_lo_q  <= '0;
      s3_hi_q  <= '0;
    end else begin
      s3_vld_q <= s2_vld_q;
      s3_sum_q <= $signed({2'b00, s2_pr_q}) - $signed({2'b00, s2_pg_q})
                - $signed({2'b00, s2_pb_q});
      s3_h_q   <= s2_h_q;
      s3_v_q   <= s2_v_q;
      s3_lo_q  <= s2_lo_q;
      s3_hi_q  <= s2_hi_q;
    end
  end

  // S4 combinational: floor shift keeps Cr in 16..239, so the 8-bit wrap
  // of the +128 offset is exact. Warm-up slots (no pixel yet) read 0.
  logic [7:0] w_s4_cr;
  logic       w_s4_m;

  assign w_s4_cr = s3_vld_q ? (8'(s3_sum_q >>> 8) + 8'd128) : 8'd0;
  assign w_s4_m  = s3_vld_q && (s3_lo_q <= w_s4_cr) && (w_s4_cr <= s3_hi_q)
                && (s3_h_q < c_h_act) && (s3_v_q < c_v_act);

  // Final-stage view feeding the output registers and the counter
  logic        w_fin_vld;
  logic [10:0] w_fin_h;
  logic [9:0]  w_fin_v;
  logic [7:0]  w_fin_cr;
  logic        w_fin_m;

`ifdef CR_MASK_ERODE_EN
  logic        s4_vld_q;
  logic [10:0] s4_h_q;
  logic [9:0]  s4_v_q;
  logic [7:0]  s4_cr_q;
  logic        s4_m_q;
  logic        prv_m_q;
  logic [9:0]  prv_v_q;

  // Raw-mask stage plus a one-pixel history for the left neighbour
  always_ff @(posedge clk_65mhz or negedge rst_in) begin
    if (!rst_in) begin
      s4_vld_q <= 1'b0;
      s4_h_q   <= '0;
      s4_v_q   <= '0;
      s4_cr_q  <= '0;
      s4_m_q   <= 1'b0;
      prv_m_q  <= 1'b0;
      prv_v_q  <= '0;
    end else begin
      s4_vld_q <= s3_vld_q;
      s4_h_q   <= s3_h_q;
      s4_v_q   <= s3_v_q;
      s4_cr_q  <= w_s4_cr;
      s4_m_q   <= w_s4_m;
      prv_m_q  <= s4_m_q;
      prv_v_q  <= s4_v_q;
    end
  end

  // Centre = registered S4 pixel, right neighbour = pixel now leaving S3.
  // Out-of-active neighbours already carry a 0 raw mask.
  assign w_fin_vld = s4_vld_q;
  assign w_fin_h   = s4_h_q;
  assign w_fin_v   = s4_v_q;
  assign w_fin_cr  = s4_cr_q;
  assign w_fin_m   = s4_m_q && prv_m_q && (prv_v_q == s4_v_q)
                  && w_s4_m && (s3_v_q == s4_v_q);
`else
  assign w_fin_vld = s3_vld_q;
  assign w_fin_h   = s3_h_q;
  assign w_fin_v   = s3_v_q;
  assign w_fin_cr  = w_s4_cr;
  assign w_fin_m   = w_s4_m;
`endif

  // Frame start detected on the final-stage inputs so that the count pulse
  // lands in the same cycle as hcount_out==0 && vcount_out==0.
  logic             w_fs_out;
  logic [CNT_W-1:0] cnt_d, cnt_q;

  assign w_fs_out = w_fin_vld && (w_fin_h == '0) && (w_fin_v == '0);
  assign cnt_d    = w_fs_out ? CNT_W'(w_fin_m)
                  : ((w_fin_m && (cnt_q != c_cnt_max)) ? cnt_q + CNT_W'(1) : cnt_q);

  // Output registers and saturating per-frame mask counter
  always_ff @(posedge clk_65mhz or negedge rst_in) begin
    if (!rst_in) begin
      hcount_out      <= '0;
      vcount_out      <= '0;
      cr_out          <= '0;
      mask_out        <= 1'b0;
      count_out       <= '0;
      count_valid_out <= 1'b0;
      cnt_q           <= '0;
    end else begin
      hcount_out      <= w_fin_h;
      vcount_out      <= w_fin_v;
      cr_out          <= w_fin_cr;
      mask_out        <= w_fin_m;
      count_valid_out <= w_fs_out;
      cnt_q           <= cnt_d;
      if (w_fs_out) begin
        count_out <= cnt_q;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_cr_mask_pipe.sv
`default_nettype none
// ============================================================================
// Module   : tb_cr_mask_pipe
// Function : Self-checking bench for cr_mask_pipe. A spec-level model
//            (integer Cr formula, per-frame window shadow, per-frame count)
//            is checked every cycle; directed probes pin literal values.
// Revision : 1.0 - initial release
// ============================================================================
module tb_cr_mask_pipe;

`ifdef CR_MASK_ERODE_EN
  localparam int TB_LAT   = 5;
  localparam bit TB_ERODE = 1'b1;
`else
  localparam int TB_LAT   = 4;
  localparam bit TB_ERODE = 1'b0;
`endif
  localparam int          CNT_W  = 20;
  localparam int          FILL_H = 1200;
  localparam int          FILL_V = 5;
  localparam logic [23:0] RED    = 24'hFF0000;
  localparam logic [23:0] GREEN  = 24'h00FF00;
  localparam logic [23:0] GRAY   = 24'h808080;
  localparam int          DEPTH  = 4096;

  logic             clk_65mhz;
  logic             rst_in;
  logic [10:0]      hcount_in;
  logic [9:0]       vcount_in;
  logic [23:0]      pixel_in;
  logic [7:0]       cr_lo_in;
  logic [7:0]       cr_hi_in;
  logic [10:0]      hcount_out;
  logic [9:0]       vcount_out;
  logic [7:0]       cr_out;
  logic             mask_out;
  logic [CNT_W-1:0] count_out;
  logic             count_valid_out;

  cr_mask_pipe #(.H_ACTIVE(1024), .V_ACTIVE(768), .CNT_W(CNT_W)) dut (
    .clk_65mhz       (clk_65mhz),
    .rst_in          (rst_in),
    .hcount_in       (hcount_in),
    .vcount_in       (vcount_in),
    .pixel_in        (pixel_in),
    .cr_lo_in        (cr_lo_in),
    .cr_hi_in        (cr_hi_in),
    .hcount_out      (hcount_out),
    .vcount_out      (vcount_out),
    .cr_out          (cr_out),
    .mask_out        (mask_out),
    .count_out       (count_out),
    .count_valid_out (count_valid_out)
  );

  initial begin
    clk_65mhz = 1'b0;
    forever #5 clk_65mhz = ~clk_65mhz;
  end

  int n_chk = 0;
  int n_err = 0;

  task automatic chk(input string nm, input longint act, input longint exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Cr = 128 + floor((112R - 94G - 18B) / 256), straight from the formula
  function automatic int model_cr(input logic [23:0] p);
    int s;
    s = 112 * int'(p[23:16]) - 94 * int'(p[15:8]) - 18 * int'(p[7:0]);
    if (s >= 0) return 128 + s / 256;
    else        return 128 - ((-s + 255) / 256);
  endfunction

  // ---------------- model state: one entry per accepted pixel -------------
  int hh   [DEPTH];
  int vv   [DEPTH];
  int crv  [DEPTH];
  bit rawm [DEPTH];
  int wr = 0;
  int base = 0;
  int m_lo = 0, m_hi = 0;
  int m_cnt = 0, m_cnt_out = 0;

  // Record each accepted pixel at the clock edge, then check the outputs
  // that must be visible just after that edge.
  initial begin : cmp
    int idx, h, v, c;
    bit em, ecv;
    forever begin
      @(posedge clk_65mhz);
      if (!rst_in) begin
        base = wr; m_lo = 0; m_hi = 0; m_cnt = 0; m_cnt_out = 0;
      end else begin
        h = int'(hcount_in);
        v = int'(vcount_in);
        if (h == 0 && v == 0) begin
          m_lo = int'(cr_lo_in);
          m_hi = int'(cr_hi_in);
        end
        c = model_cr(pixel_in);
        hh[wr] = h; vv[wr] = v; crv[wr] = c;
        rawm[wr] = (m_lo <= c) && (c <= m_hi) && (h < 1024) && (v < 768);
        wr++;
        #1;
        idx = wr - TB_LAT;
        if (idx >= base) begin
          if (TB_ERODE)
            em = rawm[idx] && (idx - 1 >= base) && rawm[idx-1] && (vv[idx-1] == vv[idx])
                 && rawm[idx+1] && (vv[idx+1] == vv[idx]);
          else
            em = rawm[idx];
          if (hh[idx] == 0 && vv[idx] == 0) begin
            ecv = 1'b1; m_cnt_out = m_cnt; m_cnt = int'(em);
          end else begin
            ecv = 1'b0;
            if (em && m_cnt < (1 << CNT_W) - 1) m_cnt++;
          end
          chk("mdl_hcount", hcount_out, hh[idx]);
          chk("mdl_vcount", vcount_out, vv[idx]);
          chk("mdl_cr", cr_out, crv[idx]);
          chk("mdl_mask", mask_out, em);
          chk("mdl_cnt_valid", count_valid_out, ecv);
          chk("mdl_count", count_out, m_cnt_out);
        end else begin
          chk("warm_mask", mask_out, 0);
          chk("warm_cnt_valid", count_valid_out, 0);
          chk("warm_count", count_out, m_cnt_out);
        end
      end
    end
  end

  // ---------------- stimulus ----------------
  int g_lo = 0, g_hi = 0;

  task automatic put(input int h, input int v, input logic [23:0] p);
    hcount_in = 11'(h);
    vcount_in = 10'(v);
    pixel_in  = p;
    cr_lo_in  = 8'(g_lo);
    cr_hi_in  = 8'(g_hi);
  endtask

  task automatic send(input int h, input int v, input logic [23:0] p);
    @(negedge clk_65mhz);
    put(h, v, p);
  endtask

  // Isolated pixel surrounded by blanking fillers; checks it at LAT cycles
  task automatic probe(input string nm, input int h, input int v, input logic [23:0] p,
                       input int exp_cr, input bit exp_raw);
    send(h, v, p);
    repeat (TB_LAT - 1) send(FILL_H, FILL_V, 24'h0);
    @(negedge clk_65mhz);
    chk({nm, "_h"}, hcount_out, h);
    chk({nm, "_v"}, vcount_out, v);
    chk({nm, "_cr"}, cr_out, exp_cr);
    chk({nm, "_mask"}, mask_out, TB_ERODE ? 1'b0 : exp_raw);
  endtask

  task automatic chk_all_zero(input string nm);
    chk({nm, "_h"}, hcount_out, 0);
    chk({nm, "_v"}, vcount_out, 0);
    chk({nm, "_cr"}, cr_out, 0);
    chk({nm, "_mask"}, mask_out, 0);
    chk({nm, "_count"}, count_out, 0);
    chk({nm, "_cv"}, count_valid_out, 0);
  endtask

  initial begin : stim
    int j;
    rst_in = 1'b1;
    put(FILL_H, FILL_V, 24'h0);
    #2 rst_in = 1'b0;
    #1 chk_all_zero("reset");
    @(negedge clk_65mhz);
    rst_in = 1'b1;

    // Frame 1: window 200..255
    g_lo = 200; g_hi = 255;
    probe("fs1", 0, 0, 24'h0, 128, 0);
    chk("fs1_pulse", count_valid_out, 1);
    chk("fs1_count", count_out, 0);
    probe("red", 10, 10, RED, 239, 1);
    probe("gray", 11, 10, GRAY, 128, 0);
    probe("green", 12, 10, GREEN, 34, 0);
    probe("blank_h", 1100, 10, RED, 239, 0);
    probe("blank_v", 10, 770, RED, 239, 0);

    // Mid-frame window change has no effect until the next frame start
    g_lo = 0; g_hi = 100;
    probe("shadow_a", 500, 300, RED, 239, 1);
    probe("shadow_b", 600, 300, RED, 239, 1);

    // Frame 2: window 0..100 now active
    probe("fs2", 0, 0, GREEN, 34, 1);
    chk("fs2_count", count_out, TB_ERODE ? 0 : 3);
    probe("f2_red", 10, 1, RED, 239, 0);
    probe("f2_green", 11, 1, GREEN, 34, 1);

    // Frame 3: exactly 10 red active pixels
    g_lo = 200; g_hi = 255;
    probe("fs3", 0, 0, 24'h0, 128, 0);
    chk("fs3_count", count_out, TB_ERODE ? 0 : 2);
    for (int i = 0; i < 10; i++) send(100 + i, 2, RED);

    // Frame 4: empty
    probe("fs4", 0, 0, 24'h0, 128, 0);
    chk("cnt10_pulse", count_valid_out, 1);
    chk("cnt10", count_out, TB_ERODE ? 8 : 10);
    @(negedge clk_65mhz);
    chk("cnt10_pulse_end", count_valid_out, 0);

    // Frame 5: red run h=20..24 then a lone red pixel
    probe("fs5", 0, 0, 24'h0, 128, 0);
    chk("cnt_empty", count_out, 0);
    chk("cnt_empty_pulse", count_valid_out, 1);
    for (int k = 0; k < 5 + TB_LAT + 1; k++) begin
      @(negedge clk_65mhz);
      if (k >= TB_LAT && k < 5 + TB_LAT) begin
        j = k - TB_LAT;
        chk("run_h", hcount_out, 20 + j);
        chk("run_mask", mask_out, TB_ERODE ? (j >= 1 && j <= 3) : 1'b1);
      end
      if (k < 5) put(20 + k, 50, RED);
      else       put(FILL_H, FILL_V, 24'h0);
    end
    probe("single", 40, 50, RED, 239, 1);
    probe("fs6", 0, 0, 24'h0, 128, 0);
    chk("cnt_run", count_out, TB_ERODE ? 3 : 6);

    // Asynchronous reset mid-stream, asserted between clock edges
    send(30, 60, RED);
    send(31, 60, RED);
    @(negedge clk_65mhz);
    #2 rst_in = 1'b0;
    #1 chk_all_zero("mid_reset");
    @(negedge clk_65mhz);
    rst_in = 1'b1;
    probe("post_rst", 10, 10, RED, 239, 0);

    repeat (3) send(FILL_H, FILL_V, 24'h0);
    @(negedge clk_65mhz);
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: got timeout, expected stimulus completion");
    $fatal(1, "watchdog expired");
  end

endmodule
`default_nettype wire

// File: doc/cr_mask_pipe.md
Name: cr_mask_pipe

Overview:
- Pixel-rate upstream stage for the line-fit path.
- Converts camera RGB888 pixels to the Cr chroma component and thresholds Cr against a programmable window.
- Produces mask_out together with hcount_out/vcount_out, all delayed by the same number of cycles, so the linear-regression stage receives the mask and pixel coordinates in the same cycle.
- Also reports the per-frame masked-pixel count, which downstream uses to gate unreliable fits.

Parameters:
- H_ACTIVE, 1024, active pixels per line; hcount >= H_ACTIVE is blanking.
- V_ACTIVE, 768, active lines per frame; vcount >= V_ACTIVE is blanking.
- CNT_W, 20, width of the masked-pixel counter.

Ports:
- clk_65mhz  input  1  pixel clock.
- rst_in  input  1  asynchronous, active-low reset.
- hcount_in  input  11  pixel column.
- vcount_in  input  10  pixel row.
- pixel_in  input  24  {R[23:16], G[15:8], B[7:0]}, unsigned.
- cr_lo_in  input  8  lower Cr bound, inclusive.
- cr_hi_in  input  8  upper Cr bound, inclusive.
- hcount_out  output  11  hcount_in delayed by LAT.
- vcount_out  output  10  vcount_in delayed by LAT.
- cr_out  output  8  computed Cr, aligned with mask_out.
- mask_out  output  1  Cr within [lo, hi] and pixel in active video.
- count_out  output  CNT_W  masked-pixel total of the previous frame.
- count_valid_out  output  1  one-cycle pulse when count_out updates.

Behaviour:
- Reset: asserting rst_in low clears all pipeline registers, outputs, the counter and the active thresholds immediately, without waiting for a clock edge. Outputs read 0; active lo/hi = 0.
- Pipeline, LAT = 4 cycles, one pixel accepted every cycle, no stalls:
  - S1 registers the inputs.
  - S2 forms the unsigned products 112*R, 94*G and 18*B, each 15 bits.
  - S3 forms the 17-bit signed sum 112R - 94G - 18B.
  - S4 computes Cr = 128 + (sum >>> 8) using an arithmetic (floor) shift, then the compare and the active-video test.
- Cr range: Cr is provably within 16..239 for all inputs, so no clamp is needed. Cr truncates to 8 bits.
- Mask rule: mask = (lo_act <= Cr) && (Cr <= hi_act) && (h < H_ACTIVE) && (v < V_ACTIVE), using the coordinates delayed to S4.
- Inverted window: if lo_act > hi_act, mask is always 0.
- Threshold shadowing:
  - lo_act/hi_act load from cr_lo_in/cr_hi_in only on the cycle where hcount_in==0 && vcount_in==0, at the input side.
  - That pixel and the whole following frame use the new values.
  - Mid-frame changes to cr_*_in have no effect until the next frame start.
- Counter:
  - Increments on each cycle where the S4 mask is 1; it saturates at 2^CNT_W-1 and does not wrap.
  - Aligned frame start is the cycle where hcount_out==0 && vcount_out==0, i.e. the output-side coordinates. On that cycle:
    - count_out latches the counter value;
    - count_valid_out pulses for one cycle;
    - the counter restarts at 1 if that pixel's mask is 1, otherwise 0.
- First frame start after reset reports count_out = 0, with a pulse.
- Coordinates are not checked for wrap consistency; a frame start is purely the (0,0) match.

Optional Feature:
- Macro: CR_MASK_ERODE_EN.
- When defined:
  - A 3-tap horizontal erosion is added after S4: mask_out = m[x-1] & m[x] & m[x+1].
  - A neighbour is treated as 0 if it is in a different line (vcount differs) or outside active video.
  - LAT becomes 5; hcount_out, vcount_out and cr_out are delayed to match.
  - The counter counts the eroded mask.
- When undefined: LAT = 4 and mask_out is the raw S4 mask.

Test Plan:
- Reset mid-stream: hold rst_in low on a non-clock-edge time -> all outputs 0 before the next edge; after release, the first valid outputs appear 4 cycles after the first input.
- Colour points with lo=200, hi=255, h=10, v=10:
  - R=255,G=0,B=0 -> cr_out=239, mask_out=1, hcount_out=10 exactly 4 cycles later.
  - 128,128,128 -> Cr=128, mask 0.
  - 0,255,0 -> Cr=34, mask 0.
- Blanking: pure red at hcount_in=1100, or at vcount_in=770 -> mask_out=0, cr_out=239.
- Threshold shadowing: change to lo=0,hi=100 at (500,300) mid-frame -> red pixels still masked for the rest of the frame; in the next frame red gives mask 0 and green (Cr=34) gives mask 1.
- Counting: a frame with exactly 10 red active pixels (lo=200,hi=255) -> at the next aligned (0,0): count_out=10, count_valid_out high one cycle; a following frame with none -> count_out=0.
- CR_MASK_ERODE_EN: red run at h=20..24 on one line -> mask_out=1 only for h=21..23, 5-cycle latency; a single red pixel -> no mask.
